// File: rtl/fp_maxpool2x2_if.sv
// Streaming pixel interface for the FP32 2x2 max-pool: pixel in with Valid_In,
// pooled result out with a Valid_Out pulse and an end-of-frame marker.
interface fp_maxpool2x2_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 Valid_In;
  logic [BUS_WIDTH-1:0] data_i;
  logic                 Valid_Out;
  logic [BUS_WIDTH-1:0] data_o;
  logic                 frame_done;

  modport master (
    output Valid_In,
    output data_i,
    input  Valid_Out,
    input  data_o,
    input  frame_done
  );

  modport slave (
    input  Valid_In,
    input  data_i,
    output Valid_Out,
    output data_o,
    output frame_done
  );
endinterface

// File: rtl/fp_maxpool2x2.sv
// Streaming 2x2/stride-2 FP32 max-pool over a raster-order feature map using a half-row line buffer.
// Optional: define MAXPOOL_NAN_PROP_EN to make NaN dominate and emit canonical 32'h7FC00000.
module fp_maxpool2x2 #(
  parameter int BUS_WIDTH  = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic             clk,
  input  logic             rst,
  fp_maxpool2x2_if.slave   bus
);

  localparam int HALF  = IMG_WIDTH / 2;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int LB_AW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic {ROW_EVEN, ROW_ODD} state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // True when the newer operand b strictly beats the older operand a.
  function automatic logic b_wins(input logic [31:0] a, input logic [31:0] b);
    logic [30:0] ma;
    logic [30:0] mb;
    ma = a[30:0];
    mb = b[30:0];
`ifdef MAXPOOL_NAN_PROP_EN
    if (is_nan(a)) return 1'b0;
    if (is_nan(b)) return 1'b1;
`endif
    if ((ma == 31'd0) && (mb == 31'd0)) return 1'b0;
    if (a[31] != b[31])                 return a[31];
    if (!a[31])                         return mb > ma;
    return mb < ma;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] w;
    w = b_wins(a, b) ? b : a;
`ifdef MAXPOOL_NAN_PROP_EN
    if (is_nan(w)) w = 32'h7FC00000;
`endif
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              valid_out_q, valid_out_d;
  logic              frame_done_q, frame_done_d;
  logic [31:0]       data_o_q, data_o_d;
  logic [31:0]       hold_q, hold_d;
  logic [31:0]       linebuf_q [HALF];

  logic              col_last;
  logic              row_last;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_idx;
  logic [31:0]       lb_rd;
  logic [31:0]       pair;

  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_idx   = LB_AW'(col_q >> 1);
  assign lb_rd    = linebuf_q[lb_idx];
  assign pair     = fmax(hold_q, bus.data_i);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    data_o_d     = data_o_q;
    hold_d       = hold_q;
    lb_we        = 1'b0;
    if (bus.Valid_In) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) begin
        row_d   = row_last ? '0 : row_q + RW'(1);
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end
      if (!col_q[0]) begin
        hold_d = bus.data_i;
      end else begin
        case (state_q)
          ROW_EVEN: lb_we = 1'b1;
          ROW_ODD: begin
            valid_out_d  = 1'b1;
            data_o_d     = fmax(lb_rd, pair);
            frame_done_d = col_last && row_last;
          end
          default: ;
        endcase
      end
    end
  end

  // Control and output stage: reset abandons any partial window immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ROW_EVEN;
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_o_q     <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      data_o_q     <= data_o_d;
    end
  end

  // Datapath storage carries no reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (lb_we) linebuf_q[lb_idx] <= pair;
  end

  assign bus.Valid_Out  = valid_out_q;
  assign bus.data_o     = data_o_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fp_maxpool2x2.sv
// Scoreboard bench for fp_maxpool2x2 on a 4x2 image: stimulus pushes expected pulses, a monitor pops them.
module tb_fp_maxpool2x2;

  typedef struct {
    logic [31:0] d;
    logic        fd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t expq[$];

  fp_maxpool2x2_if #(.BUS_WIDTH(32)) bus ();

  fp_maxpool2x2 #(.BUS_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Drive one pixel; it is captured on the next rising edge.
  task automatic pix(input logic [31:0] d, input bit ev, input logic [31:0] ed, input bit efd);
    exp_t e;
    bus.Valid_In = 1'b1;
    bus.data_i   = d;
    @(posedge clk);
    #1;
    if (ev) begin
      e.d = ed; e.fd = efd; e.cyc = cyc;
      expq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bus.Valid_In = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pixels listed row-major, index 0 first; windows close on indices 5 and 7.
  task automatic frame(input logic [7:0][31:0] px, input logic [31:0] e0,
                       input logic [31:0] e1, input int maxidle);
    for (int i = 0; i < 8; i++) begin
      pix(px[i], (i == 5) || (i == 7), (i == 5) ? e0 : e1, i == 7);
      if (maxidle > 0) idle($urandom_range(0, maxidle));
    end
  endtask

  function automatic logic [7:0][31:0] mk(input logic [31:0] p0, p1, p2, p3, p4, p5, p6, p7);
    logic [7:0][31:0] r;
    r[0] = p0; r[1] = p1; r[2] = p2; r[3] = p3;
    r[4] = p4; r[5] = p5; r[6] = p6; r[7] = p7;
    return r;
  endfunction

  // Monitor: every Valid_Out pulse must match the oldest expectation, data, marker and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Valid_Out) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: got data_o %h at cycle %0d required no pulse", bus.data_o, cyc);
        end else begin
          e = expq.pop_front();
          chk("data_o", bus.data_o, e.d);
          chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
          chk("latency_cycle", cyc, e.cyc);
        end
      end else if (bus.frame_done) begin
        checks++;
        $display("FAIL stray_frame_done: got 1 at cycle %0d required 0", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][31:0] t1, t1n, t3, t6;
    logic [31:0] nan_exp;
    t1  = mk(32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0400000,
             32'h3F000000, 32'h40800000, 32'hC0000000, 32'hBF000000);
    t1n = mk(32'hBF800000, 32'hC0000000, 32'h3F800000, 32'h40400000,
             32'hBF000000, 32'hC0800000, 32'h40000000, 32'h3F000000);
    t3  = mk(32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
             32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000);
    t6  = mk(32'h3F800000, 32'h7FC00001, 32'h00000000, 32'h00000000,
             32'h40000000, 32'hBF800000, 32'h00000000, 32'h00000000);
`ifdef MAXPOOL_NAN_PROP_EN
    nan_exp = 32'h7FC00000;
`else
    nan_exp = 32'h7FC00001;
`endif
    bus.Valid_In = 1'b0;
    bus.data_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_out", {31'd0, bus.Valid_Out}, 32'd0);
    chk("reset_data_o", bus.data_o, 32'd0);
    chk("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    frame(t1, 32'h40800000, 32'hBF000000, 0);
    idle(3);
    frame(t1, 32'h40800000, 32'hBF000000, 3);
    idle(3);
    frame(t3, 32'h80000000, 32'h3F800000, 0);
    idle(3);
    // Back-to-back frames; max of the negated frame is not the negated max.
    frame(t1, 32'h40800000, 32'hBF000000, 0);
    frame(t1n, 32'hBF000000, 32'h40400000, 0);
    idle(3);

    // Reset mid-frame after the first window closes.
    for (int i = 0; i < 6; i++) pix(t1[i], i == 5, 32'h40800000, 1'b0);
    idle(1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_valid_out", {31'd0, bus.Valid_Out}, 32'd0);
      chk("midreset_data_o", bus.data_o, 32'd0);
      chk("midreset_frame_done", {31'd0, bus.frame_done}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    frame(t1, 32'h40800000, 32'hBF000000, 0);
    idle(3);

    frame(t6, nan_exp, 32'h00000000, 1);
    idle(5);
    chk("scoreboard_drained", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
